// File: rtl/gpu_op_arbiter.sv
// Round-robin arbiter sharing the GPU op FIFO write port between N_REQ requesters,
// plus end-of-frame sequencing: drain the GPU, wait for a vsync rising edge, pulse swap.
module gpu_op_arbiter #(
  parameter int unsigned N_REQ           = 2,
  parameter int unsigned OP_WIDTH        = 64,
  parameter int unsigned FRAME_CNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ce,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ*OP_WIDTH-1:0]    req_op,
  output logic [N_REQ-1:0]             req_ready,
  input  logic [N_REQ-1:0]             req_frame_done,
  output logic [OP_WIDTH-1:0]          op,
  output logic                         op_wr_en,
  input  logic                         op_full,
  input  logic                         gpu_busy,
  input  logic                         vsync,
  output logic                         swap,
  output logic [$clog2(N_REQ)-1:0]     grant_idx,
  output logic [FRAME_CNT_WIDTH-1:0]   frame_count,
  output logic [1:0]                   state_dbg
);

  localparam int unsigned IdxW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    StRun       = 2'd0,
    StDrain     = 2'd1,
    StWaitVsync = 2'd2,
    StSwap      = 2'd3
  } state_e;

  state_e            state_q;
  logic [IdxW-1:0]   rr_ptr_q;
  logic [N_REQ-1:0]  done_mask_q;
  logic              vsync_d_q;

  logic [N_REQ-1:0]  eligible;
  logic [IdxW-1:0]   idx;
  logic [IdxW-1:0]   winner;
  logic [IdxW-1:0]   rr_next;
  logic              found;
  logic              grant;

  assign eligible = req_valid & ~done_mask_q;

  // Rotating priority search starting at rr_ptr_q.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = IdxW'((32'(rr_ptr_q) + k) % N_REQ);
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // The !op_wr_en term spaces writes two cycles apart so op_full reflects the previous write.
  assign grant = (state_q == StRun) && ce && !rst && !op_full && !op_wr_en && found;

  assign rr_next = (32'(winner) == N_REQ - 1) ? '0 : winner + 1'b1;

  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready[winner] = 1'b1;
    end
  end

  assign state_dbg = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      rr_ptr_q    <= '0;
      done_mask_q <= '0;
      vsync_d_q   <= 1'b0;
      op          <= '0;
      op_wr_en    <= 1'b0;
      swap        <= 1'b0;
      grant_idx   <= '0;
      frame_count <= '0;
    end else if (!ce) begin
      op_wr_en <= 1'b0;
      swap     <= 1'b0;
    end else begin
      op_wr_en <= grant;
      swap     <= 1'b0;

      if (grant) begin
        op        <= req_op[winner*OP_WIDTH +: OP_WIDTH];
        grant_idx <= winner;
        rr_ptr_q  <= rr_next;
      end

      // Sampled every enabled cycle so a vsync already high on WAIT_VSYNC entry is not an edge.
      vsync_d_q <= vsync;

      if (state_q != StSwap) begin
        done_mask_q <= done_mask_q | req_frame_done;
      end

      unique case (state_q)
        StRun: begin
          if (&done_mask_q) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (!op_wr_en && !gpu_busy) begin
            state_q <= StWaitVsync;
          end
        end
        StWaitVsync: begin
          if (vsync && !vsync_d_q) begin
            state_q     <= StSwap;
            swap        <= 1'b1;
            frame_count <= frame_count + 1'b1;
            done_mask_q <= '0;
          end
        end
        StSwap: begin
          state_q <= StRun;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_op_arbiter.sv
// Self-checking bench for gpu_op_arbiter: directed vector table, hand-written frame
// sequences, and randomized stimulus against a cycle-level reference model.
module tb_gpu_op_arbiter;

  localparam int N  = 2;
  localparam int OW = 64;
  localparam int FW = 16;
  localparam int GW = $clog2(N);
  localparam logic [63:0] OP_A = 64'hA;
  localparam logic [63:0] OP_B = 64'hB;

  logic            clk = 1'b0;
  logic            rst;
  logic            ce;
  logic [N-1:0]    req_valid;
  logic [N*OW-1:0] req_op;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_frame_done;
  logic [OW-1:0]   op;
  logic            op_wr_en;
  logic            op_full;
  logic            gpu_busy;
  logic            vsync;
  logic            swap;
  logic [GW-1:0]   grant_idx;
  logic [FW-1:0]   frame_count;
  logic [1:0]      state_dbg;

  always #5 clk = ~clk;

  gpu_op_arbiter #(
    .N_REQ(N),
    .OP_WIDTH(OW),
    .FRAME_CNT_WIDTH(FW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ce(ce),
    .req_valid(req_valid),
    .req_op(req_op),
    .req_ready(req_ready),
    .req_frame_done(req_frame_done),
    .op(op),
    .op_wr_en(op_wr_en),
    .op_full(op_full),
    .gpu_busy(gpu_busy),
    .vsync(vsync),
    .swap(swap),
    .grant_idx(grant_idx),
    .frame_count(frame_count),
    .state_dbg(state_dbg)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: phase 0=RUN 1=DRAIN 2=WAIT_VSYNC 3=SWAP.
  int            m_state;
  int            m_rr;
  logic [N-1:0]  m_done;
  logic          m_vs;
  logic [OW-1:0] m_op;
  logic          m_wr;
  logic          m_swap;
  int            m_gidx;
  int            m_fc;

  // Values sampled by the most recent step.
  logic [N-1:0]  s_ready;
  logic          s_wr;
  logic [OW-1:0] s_op;
  logic          s_swap;
  logic [GW-1:0] s_gidx;
  logic [FW-1:0] s_fc;
  logic [1:0]    s_state;

  typedef struct {
    logic        rst;
    logic        ce;
    logic [1:0]  valid;
    logic        full;
    logic [1:0]  exp_ready;
    logic        exp_wr;
    logic [63:0] exp_op;
    logic        exp_gidx;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_rr    = 0;
    m_done  = '0;
    m_vs    = 1'b0;
    m_op    = '0;
    m_wr    = 1'b0;
    m_swap  = 1'b0;
    m_gidx  = 0;
    m_fc    = 0;
  endtask

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    r = '0;
    if (rst || !ce || m_state != 0 || op_full || m_wr) return r;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_rr + k) % N;
      if (req_valid[i] && !m_done[i]) begin
        r[i] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  task automatic model_update();
    logic [N-1:0] r;
    logic         nwr;
    logic         nsw;
    logic [N-1:0] nd;
    if (rst) begin
      model_reset();
    end else if (!ce) begin
      m_wr   = 1'b0;
      m_swap = 1'b0;
    end else begin
      r   = model_ready();
      nwr = 1'b0;
      nsw = 1'b0;
      nd  = m_done;
      for (int i = 0; i < N; i++) begin
        if (r[i]) begin
          m_op   = req_op[i*OW +: OW];
          nwr    = 1'b1;
          m_gidx = i;
          m_rr   = (i + 1) % N;
        end
      end
      if (m_state != 3) nd = nd | req_frame_done;
      case (m_state)
        0: if (m_done == {N{1'b1}}) m_state = 1;
        1: if (!m_wr && !gpu_busy) m_state = 2;
        2: if (vsync && !m_vs) begin
             m_state = 3;
             nsw     = 1'b1;
             m_fc    = (m_fc + 1) % (1 << FW);
             nd      = '0;
           end
        default: m_state = 0;
      endcase
      m_vs   = vsync;
      m_wr   = nwr;
      m_swap = nsw;
      m_done = nd;
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".ready"}, 64'(req_ready), 64'(model_ready()));
    chk({tag, ".wr_en"}, 64'(op_wr_en), 64'(m_wr));
    chk({tag, ".op"}, op, m_op);
    chk({tag, ".swap"}, 64'(swap), 64'(m_swap));
    chk({tag, ".grant_idx"}, 64'(grant_idx), 64'(m_gidx));
    chk({tag, ".frame_count"}, 64'(frame_count), 64'(m_fc));
    chk({tag, ".state"}, 64'(state_dbg), 64'(m_state));
  endtask

  // Inputs are set just after a rising edge; outputs are sampled on the falling edge.
  task automatic step(input string tag);
    @(negedge clk);
    s_ready = req_ready;
    s_wr    = op_wr_en;
    s_op    = op;
    s_swap  = swap;
    s_gidx  = grant_idx;
    s_fc    = frame_count;
    s_state = state_dbg;
    check_outputs(tag);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic wait_state(input logic [1:0] target, input int max, input string name);
    for (int i = 0; i < max; i++) begin
      step(name);
      if (s_state == target) break;
    end
    chk({name, ".reached"}, 64'(s_state), 64'(target));
  endtask

  task automatic add_vec(input logic r, input logic c, input logic [1:0] v, input logic f,
                         input logic [1:0] er, input logic ew, input logic [63:0] eo,
                         input logic eg);
    vec_t x;
    x.rst = r; x.ce = c; x.valid = v; x.full = f;
    x.exp_ready = er; x.exp_wr = ew; x.exp_op = eo; x.exp_gidx = eg;
    tbl.push_back(x);
  endtask

  task automatic pulse_done(input logic [N-1:0] mask);
    req_frame_done = mask;
    step("done_pulse");
    req_frame_done = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r0_grants;
    int rem1;
    int wr_cnt;
    int first_wr;
    int last_wr;
    int swaps;

    rst = 1'b1; ce = 1'b1; req_valid = '0; req_frame_done = '0;
    op_full = 1'b0; gpu_busy = 1'b0; vsync = 1'b0;
    req_op = {OP_B, OP_A};
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;

    //      rst  ce  valid  full  ready  wr  op    gidx
    add_vec(0,   1,  2'b11, 0,    2'b01, 0,  0,    0);
    add_vec(0,   1,  2'b11, 0,    2'b00, 1,  OP_A, 0);
    add_vec(0,   1,  2'b11, 0,    2'b10, 0,  OP_A, 0);
    add_vec(0,   1,  2'b11, 0,    2'b00, 1,  OP_B, 1);
    add_vec(0,   1,  2'b11, 0,    2'b01, 0,  OP_B, 1);
    add_vec(0,   1,  2'b11, 0,    2'b00, 1,  OP_A, 0);
    for (int i = 0; i < 5; i++) add_vec(0, 1, 2'b01, 1, 2'b00, 0, OP_A, 0);
    add_vec(0,   1,  2'b01, 0,    2'b01, 0,  OP_A, 0);
    add_vec(0,   1,  2'b01, 0,    2'b00, 1,  OP_A, 0);
    add_vec(0,   1,  2'b00, 0,    2'b00, 0,  OP_A, 0);
    add_vec(0,   0,  2'b11, 0,    2'b00, 0,  OP_A, 0);
    add_vec(0,   1,  2'b11, 0,    2'b10, 0,  OP_A, 0);
    add_vec(0,   1,  2'b11, 0,    2'b00, 1,  OP_B, 1);
    add_vec(1,   1,  2'b11, 0,    2'b00, 0,  OP_B, 1);
    add_vec(0,   1,  2'b11, 0,    2'b01, 0,  0,    0);

    foreach (tbl[i]) begin
      rst = tbl[i].rst; ce = tbl[i].ce; req_valid = tbl[i].valid; op_full = tbl[i].full;
      step($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.tbl_ready", i), 64'(s_ready), 64'(tbl[i].exp_ready));
      chk($sformatf("vec%0d.tbl_wr", i), 64'(s_wr), 64'(tbl[i].exp_wr));
      chk($sformatf("vec%0d.tbl_op", i), s_op, tbl[i].exp_op);
      chk($sformatf("vec%0d.tbl_gidx", i), 64'(s_gidx), 64'(tbl[i].exp_gidx));
    end

    // Frame done from requester 0 coinciding with its own transfer; requester 1 sends 4 ops.
    rst = 1'b1; req_valid = '0; step("rstA");
    rst = 1'b0; ce = 1'b1;
    req_valid = 2'b11; req_frame_done = 2'b01;
    step("coincide");
    chk("coincide.ready", 64'(s_ready), 64'(2'b01));
    req_frame_done = '0;
    r0_grants = 0; rem1 = 4; wr_cnt = 0; first_wr = -1; last_wr = -1;
    for (int i = 0; i < 12; i++) begin
      req_valid = {(rem1 > 0), 1'b1};
      step("req1_ops");
      if (i == 0) chk("coincide.op_written", s_op, OP_A);
      if (s_ready[0]) r0_grants++;
      if (s_ready[1]) rem1--;
      if (s_wr && s_gidx == 1'b1) begin
        wr_cnt++;
        if (first_wr < 0) first_wr = i;
        last_wr = i;
      end
    end
    chk("done0.no_more_ready", 64'(r0_grants), 64'(0));
    chk("req1.write_count", 64'(wr_cnt), 64'(4));
    chk("req1.write_span", 64'(last_wr - first_wr), 64'(6));

    // Drain with a busy GPU, then a vsync edge 20 cycles later.
    req_valid = '0;
    pulse_done(2'b10);
    gpu_busy = 1'b1;
    wait_state(2'd1, 6, "drain");
    for (int i = 0; i < 10; i++) step("drain_busy");
    chk("drain.held", 64'(s_state), 64'(1));
    gpu_busy = 1'b0;
    wait_state(2'd2, 4, "wait_vsync");
    swaps = 0;
    for (int i = 0; i < 20; i++) begin
      step("vs_low");
      if (s_swap) swaps++;
    end
    chk("vs_low.no_swap", 64'(swaps), 64'(0));
    vsync = 1'b1;
    step("vs_edge");
    chk("vs_edge.swap", 64'(s_swap), 64'(0));
    step("swap");
    chk("swap.pulse", 64'(s_swap), 64'(1));
    chk("swap.frame_count", 64'(s_fc), 64'(1));
    chk("swap.state", 64'(s_state), 64'(3));
    req_valid = 2'b01;
    step("post_swap");
    chk("post_swap.swap", 64'(s_swap), 64'(0));
    chk("post_swap.state", 64'(s_state), 64'(0));
    chk("mask_cleared.ready", 64'(s_ready), 64'(2'b01));
    req_valid = '0;
    step("idle");

    // vsync already high when WAIT_VSYNC is entered must not count as an edge.
    pulse_done(2'b11);
    wait_state(2'd2, 8, "b_wait");
    swaps = 0;
    for (int i = 0; i < 6; i++) begin
      step("b_high");
      if (s_swap) swaps++;
    end
    chk("b_high.no_swap", 64'(swaps), 64'(0));
    chk("b_high.state", 64'(s_state), 64'(2));
    vsync = 1'b0; step("b_low");
    vsync = 1'b1; step("b_edge");
    step("b_swap");
    chk("b_swap.pulse", 64'(s_swap), 64'(1));
    chk("b_swap.frame_count", 64'(s_fc), 64'(2));
    step("b_after");

    // Reach frame_count 3, then reset during WAIT_VSYNC.
    pulse_done(2'b11);
    wait_state(2'd2, 8, "c_wait");
    vsync = 1'b0; step("c_low");
    vsync = 1'b1; step("c_edge");
    step("c_swap");
    chk("c_swap.frame_count", 64'(s_fc), 64'(3));
    step("c_after");
    pulse_done(2'b11);
    wait_state(2'd2, 8, "c_wait2");
    vsync = 1'b0; step("c_low2");
    rst = 1'b1; step("c_rst");
    rst = 1'b0; vsync = 1'b1; req_valid = 2'b01;
    step("rst_resume");
    chk("rst_resume.swap", 64'(s_swap), 64'(0));
    chk("rst_resume.frame_count", 64'(s_fc), 64'(0));
    chk("rst_resume.state", 64'(s_state), 64'(0));
    chk("rst_resume.ready", 64'(s_ready), 64'(2'b01));
    step("rst_resume2");
    chk("rst_resume2.wr", 64'(s_wr), 64'(1));
    chk("rst_resume2.swap", 64'(s_swap), 64'(0));

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      ce = ($urandom_range(0, 9) != 0);
      req_valid = N'($urandom);
      op_full = ($urandom_range(0, 3) == 0);
      gpu_busy = ($urandom_range(0, 2) == 0);
      for (int j = 0; j < N; j++) req_frame_done[j] = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0) vsync = ~vsync;
      for (int j = 0; j < N; j++) req_op[j*OW +: OW] = {$urandom, $urandom};
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
